viterbi_traceback: RTL

VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

---
 rtl/viterbi_traceback.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/viterbi_traceback.sv
// Viterbi survivor-memory traceback: 128-step circular survivor store, 32-step
// sliding-window block traceback, tail-terminated flush, LIFO reorder to chronological output.
module viterbi_traceback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        di_valid,
    input  logic [63:0] di_sur,
    input  logic [5:0]  di_min_state,
    input  logic        di_last,
    output logic        do_bit,
    output logic        do_valid,
    output logic        do_last,
    output logic        do_err
);

    localparam int unsigned NS    = 64;   // trellis states
    localparam int unsigned SW    = 6;    // state width
    localparam int unsigned AW    = 7;    // survivor address / counter width
    localparam int unsigned DEPTH = 128;
    localparam int unsigned LW    = 6;    // LIFO index width
    localparam int unsigned BLK   = 32;   // skip and decode length of a block traceback
    localparam int unsigned U_LIM = 96;

    typedef enum logic [1:0] {IDLE, TB_SKIP, TB_DEC, OUT} state_t;

    state_t          state, state_d;
    logic [NS-1:0]   mem [DEPTH];
    logic [NS-1:0]   rd_data;
    logic            lifo [NS];
    logic [AW-1:0]   wr_ptr, u_cnt, addr, cnt, last_addr, sp;
    logic [SW-1:0]   tb_st, newest_ms;
    logic            flush_pend, is_flush;

    logic [AW-1:0]   rd_addr_c, u_base_c;
    logic            start_blk_c, start_flush_c, step_c, dec_done_c, pop_c;
    logic            flush_end_c, err_c, accept_c;

    // Next-state and traceback read-address selection
    always_comb begin
        state_d       = state;
        start_blk_c   = 1'b0;
        start_flush_c = 1'b0;
        rd_addr_c     = addr - AW'(1);
        case (state)
            IDLE: begin
                if (flush_pend) begin
                    state_d       = TB_DEC;
                    start_flush_c = 1'b1;
                    rd_addr_c     = last_addr;
                end else if (u_cnt >= AW'(NS) && !(di_valid && di_last)) begin
                    state_d     = TB_SKIP;
                    start_blk_c = 1'b1;
                    rd_addr_c   = wr_ptr - AW'(1);
                end
            end
            TB_SKIP: if (cnt == AW'(1)) state_d = TB_DEC;
            TB_DEC:  if (cnt == AW'(1)) state_d = OUT;
            OUT:     if (sp <= AW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign step_c      = (state == TB_SKIP) || (state == TB_DEC);
    assign dec_done_c  = (state == TB_DEC) && (cnt == AW'(1));
    assign pop_c       = (state == OUT);
    assign flush_end_c = pop_c && is_flush && (sp == AW'(1));
    // U after this cycle's block retirement; the overflow test is made against it
    assign u_base_c    = (dec_done_c && !is_flush) ? u_cnt - AW'(BLK) : u_cnt;
    assign err_c       = di_valid && (flush_pend || u_base_c >= AW'(U_LIM));
    assign accept_c    = di_valid && !err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Storage without reset: survivor RAM with registered read, and the reorder LIFO
    always_ff @(posedge clk) begin
        if (accept_c) mem[wr_ptr] <= di_sur;
        rd_data <= mem[rd_addr_c];
        if (state == TB_DEC) lifo[sp[LW-1:0]] <= tb_st[SW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            u_cnt      <= '0;
            addr       <= '0;
            cnt        <= '0;
            last_addr  <= '0;
            sp         <= '0;
            tb_st      <= '0;
            newest_ms  <= '0;
            flush_pend <= 1'b0;
            is_flush   <= 1'b0;
            do_bit     <= 1'b0;
            do_valid   <= 1'b0;
            do_last    <= 1'b0;
            do_err     <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr    <= wr_ptr + AW'(1);
                newest_ms <= di_min_state;
                if (di_last) begin
                    flush_pend <= 1'b1;
                    last_addr  <= wr_ptr;
                end
            end
            if (flush_end_c) flush_pend <= 1'b0;

            u_cnt <= (dec_done_c && is_flush) ? '0 : u_base_c + AW'(accept_c);

            if (start_blk_c) begin
                addr     <= wr_ptr - AW'(1);
                tb_st    <= newest_ms;
                cnt      <= AW'(BLK);
                is_flush <= 1'b0;
            end else if (start_flush_c) begin
                addr     <= last_addr;
                tb_st    <= '0;
                cnt      <= u_cnt;
                is_flush <= 1'b1;
            end else if (step_c) begin
                // rd_data holds the survivors of the step at addr
                addr  <= addr - AW'(1);
                tb_st <= {tb_st[SW-2:0], rd_data[tb_st]};
                cnt   <= (state == TB_SKIP && cnt == AW'(1)) ? AW'(BLK) : cnt - AW'(1);
            end

            if (state == TB_DEC) sp <= sp + AW'(1);
            else if (pop_c)      sp <= sp - AW'(1);

            do_valid <= pop_c;
            do_bit   <= pop_c ? lifo[LW'(sp - AW'(1))] : 1'b0;
            do_last  <= flush_end_c;
            do_err   <= do_err | err_c;
        end
    end

endmodule
